// File: rtl/sram_fault_model.sv
// rtl/sram_fault_model.sv - behavioural single-port SRAM with programmable fault injection
//
// Memory under test for BIST closed-loop checking. After reset the array is
// cleared one word per cycle (INIT); accesses are accepted only in READY.
// Up to NUM_FAULTS runtime slots inject SAF0/SAF1/TF/CF/AF defects.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   mem_ce/mem_we/mem_addr/mem_wdata   access request (write when mem_we=1)
//   mem_rdata/mem_rvalid       read data + one-cycle strobe, READ_LATENCY after accept
//   init_busy                  array clear in progress, accesses dropped
//   flt_wr_en/flt_clear/flt_idx/flt_type/flt_addr/flt_bit/flt_aggr_addr
//                              fault slot programming (clear wins over write)
//   fault_hit                  read was altered by an AF redirect or SAF
//   fault_hit_cnt              saturating count of fault_hit pulses
//   access_count               accepted accesses, wraps
module sram_fault_model #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_DEPTH    = 1024,
  parameter int READ_LATENCY = 1,
  parameter int NUM_FAULTS   = 4,
  parameter int FI           = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
  parameter int BW           = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_ce,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rvalid,
  output logic                  init_busy,
  input  logic                  flt_wr_en,
  input  logic                  flt_clear,
  input  logic [FI-1:0]         flt_idx,
  input  logic [2:0]            flt_type,
  input  logic [ADDR_WIDTH-1:0] flt_addr,
  input  logic [BW-1:0]         flt_bit,
  input  logic [ADDR_WIDTH-1:0] flt_aggr_addr,
  output logic                  fault_hit,
  output logic [15:0]           fault_hit_cnt,
  output logic [31:0]           access_count
);

  localparam int CW = ADDR_WIDTH + 1;

  localparam logic [2:0] T_SAF0 = 3'd1;
  localparam logic [2:0] T_SAF1 = 3'd2;
  localparam logic [2:0] T_TF   = 3'd3;
  localparam logic [2:0] T_CF   = 3'd4;
  localparam logic [2:0] T_AF   = 3'd5;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t state, state_next;
  logic [CW-1:0] init_cnt;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [2:0]            slot_type [NUM_FAULTS];
  logic [ADDR_WIDTH-1:0] slot_addr [NUM_FAULTS];
  logic [BW-1:0]         slot_bit  [NUM_FAULTS];
  logic [ADDR_WIDTH-1:0] slot_aggr [NUM_FAULTS];

  logic                  accept;
  logic                  rd_valid;
  logic                  af_found;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic                  eff_in_range;
  logic [DATA_WIDTH-1:0] stored;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [NUM_FAULTS-1:0] cf_flip;

  logic                  p1_valid;
  logic [DATA_WIDTH-1:0] p1_data;
  logic                  p1_hit;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_hit;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  if (init_cnt == CW'(MEM_DEPTH - 1)) state_next = S_READY;
      S_READY: state_next = S_READY;
      default: state_next = S_INIT;
    endcase
  end

  always_comb begin
    init_busy = (state == S_INIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_cnt <= '0;
    end else if (state == S_INIT) begin
      init_cnt <= init_cnt + CW'(1);
    end
  end

  // ---------------- fault slot registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n || flt_clear) begin
      for (int i = 0; i < NUM_FAULTS; i++) begin
        slot_type[i] <= 3'd0;
      end
    end else if (flt_wr_en && (int'(flt_idx) < NUM_FAULTS)) begin
      slot_type[flt_idx] <= flt_type;
      slot_addr[flt_idx] <= flt_addr;
      slot_bit[flt_idx]  <= flt_bit;
      slot_aggr[flt_idx] <= flt_aggr_addr;
    end
  end

  // ---------------- access path ----------------
  assign accept   = (state == S_READY) && mem_ce;
  assign rd_valid = accept && !mem_we;

  // Address decoding: the lowest-index matching AF slot redirects the access.
  always_comb begin
    af_found = 1'b0;
    eff_addr = mem_addr;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (!af_found && slot_type[i] == T_AF && slot_addr[i] == mem_addr) begin
        af_found = 1'b1;
        eff_addr = slot_aggr[i];
      end
    end
  end

  assign eff_in_range = ({1'b0, eff_addr} < CW'(MEM_DEPTH));
  assign stored       = eff_in_range ? mem[eff_addr] : '0;

  // Read data: SAF forces the victim bit in the returned word only.
  always_comb begin
    rd_data = stored;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (slot_addr[i] == eff_addr) begin
        if (slot_type[i] == T_SAF0) rd_data[slot_bit[i]] = 1'b0;
        if (slot_type[i] == T_SAF1) rd_data[slot_bit[i]] = 1'b1;
      end
    end
    rd_hit = af_found || (rd_data != stored);
  end

  // Write data: TF blocks rising victim bits; CF reacts to a rising aggressor
  // bit. A CF victim in the written word is folded into wr_word, any other
  // victim word is toggled separately through cf_flip.
  always_comb begin
    wr_word = mem_wdata;
    cf_flip = '0;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (slot_type[i] == T_TF && slot_addr[i] == eff_addr &&
          !stored[slot_bit[i]] && wr_word[slot_bit[i]]) begin
        wr_word[slot_bit[i]] = 1'b0;
      end
      if (slot_type[i] == T_CF && slot_aggr[i] == eff_addr &&
          !stored[slot_bit[i]] && wr_word[slot_bit[i]]) begin
        if (slot_addr[i] == eff_addr) begin
          wr_word[slot_bit[i]] = ~wr_word[slot_bit[i]];
        end else begin
          cf_flip[i] = 1'b1;
        end
      end
    end
  end

  // Array storage: cleared during INIT, written by accepted in-range writes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == S_INIT) begin
        mem[init_cnt[ADDR_WIDTH-1:0]] <= '0;
      end else if (accept && mem_we && eff_in_range) begin
        mem[eff_addr] <= wr_word;
        for (int i = 0; i < NUM_FAULTS; i++) begin
          if (cf_flip[i] && ({1'b0, slot_addr[i]} < CW'(MEM_DEPTH))) begin
            mem[slot_addr[i]][slot_bit[i]] <= ~mem[slot_addr[i]][slot_bit[i]];
          end
        end
      end
    end
  end

  // ---------------- read pipeline and counters ----------------
  assign out_valid = (READ_LATENCY == 2) ? p1_valid : rd_valid;
  assign out_data  = (READ_LATENCY == 2) ? p1_data  : rd_data;
  assign out_hit   = (READ_LATENCY == 2) ? p1_hit   : rd_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1_valid      <= 1'b0;
      p1_data       <= '0;
      p1_hit        <= 1'b0;
      mem_rvalid    <= 1'b0;
      mem_rdata     <= '0;
      fault_hit     <= 1'b0;
      fault_hit_cnt <= 16'd0;
      access_count  <= 32'd0;
    end else begin
      p1_valid <= rd_valid;
      p1_hit   <= rd_valid && rd_hit;
      if (rd_valid) p1_data <= rd_data;

      mem_rvalid <= out_valid;
      fault_hit  <= out_valid && out_hit;
      if (out_valid) mem_rdata <= out_data;
      if (out_valid && out_hit && fault_hit_cnt != 16'hFFFF) begin
        fault_hit_cnt <= fault_hit_cnt + 16'd1;
      end

      if (accept) access_count <= access_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_sram_fault_model.sv
// tb/tb_sram_fault_model.sv - scoreboard bench for sram_fault_model
module tb_sram_fault_model;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1024;
  localparam int NF = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_ce = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic          init_busy;
  logic          flt_wr_en = 1'b0;
  logic          flt_clear = 1'b0;
  logic [1:0]    flt_idx = '0;
  logic [2:0]    flt_type = '0;
  logic [AW-1:0] flt_addr = '0;
  logic [4:0]    flt_bit = '0;
  logic [AW-1:0] flt_aggr_addr = '0;
  logic          fault_hit;
  logic [15:0]   fault_hit_cnt;
  logic [31:0]   access_count;

  sram_fault_model dut (
    .clk(clk), .rst_n(rst_n), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .init_busy(init_busy), .flt_wr_en(flt_wr_en),
    .flt_clear(flt_clear), .flt_idx(flt_idx), .flt_type(flt_type),
    .flt_addr(flt_addr), .flt_bit(flt_bit), .flt_aggr_addr(flt_aggr_addr),
    .fault_hit(fault_hit), .fault_hit_cnt(fault_hit_cnt), .access_count(access_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        hit;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] acc_exp = 0;

  // reference model state
  logic [31:0] mm [DEPTH];
  int          m_type [NF];
  logic [9:0]  m_addr [NF];
  logic [9:0]  m_aggr [NF];
  int          m_bit  [NF];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Scanning from the top down leaves the lowest matching AF slot in force.
  function automatic logic [9:0] m_redirect(input logic [9:0] a, output logic hit);
    logic [9:0] r;
    r = a;
    hit = 1'b0;
    for (int i = NF - 1; i >= 0; i--) begin
      if (m_type[i] == 5 && m_addr[i] == a) begin
        r = m_aggr[i];
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic exp_t m_read(input logic [9:0] a);
    exp_t e;
    logic h;
    logic [9:0] ea;
    logic [31:0] d;
    ea = m_redirect(a, h);
    d = mm[ea];
    for (int i = 0; i < NF; i++) begin
      if (m_addr[i] == ea && m_type[i] == 1) d = d & ~(32'h1 << m_bit[i]);
      if (m_addr[i] == ea && m_type[i] == 2) d = d | (32'h1 << m_bit[i]);
    end
    e.data = d;
    e.hit = h || (d != mm[ea]);
    return e;
  endfunction

  function automatic void m_write(input logic [9:0] a, input logic [31:0] wd);
    logic h;
    logic [9:0] ea;
    logic [31:0] old, w, msk;
    ea = m_redirect(a, h);
    old = mm[ea];
    w = wd;
    for (int i = 0; i < NF; i++) begin
      msk = 32'h1 << m_bit[i];
      if (m_type[i] == 3 && m_addr[i] == ea && (old & msk) == 0) w = w & ~msk;
      if (m_type[i] == 4 && m_aggr[i] == ea && (old & msk) == 0 && (w & msk) != 0) begin
        if (m_addr[i] == ea) w = w ^ msk;
        else mm[m_addr[i]] = mm[m_addr[i]] ^ msk;
      end
    end
    mm[ea] = w;
  endfunction

  task automatic drive_idle();
    @(posedge clk); #1;
    mem_ce = 1'b0; mem_we = 1'b0; flt_wr_en = 1'b0; flt_clear = 1'b0;
  endtask

  task automatic op_write(input logic [9:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    flt_wr_en = 1'b0; flt_clear = 1'b0;
    m_write(a, d);
    acc_exp++;
  endtask

  task automatic op_read(input logic [9:0] a);
    @(posedge clk); #1;
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = a;
    flt_wr_en = 1'b0; flt_clear = 1'b0;
    sb_q.push_back(m_read(a));
    acc_exp++;
  endtask

  task automatic op_read_exp(input logic [9:0] a, input logic [31:0] d, input logic h);
    exp_t e;
    @(posedge clk); #1;
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = a;
    flt_wr_en = 1'b0; flt_clear = 1'b0;
    e.data = d;
    e.hit = h;
    sb_q.push_back(e);
    acc_exp++;
  endtask

  task automatic cfg(input int idx, input logic [2:0] t, input logic [9:0] va,
                     input int b, input logic [9:0] ag);
    @(posedge clk); #1;
    mem_ce = 1'b0; mem_we = 1'b0; flt_clear = 1'b0;
    flt_wr_en = 1'b1; flt_idx = idx[1:0]; flt_type = t; flt_addr = va;
    flt_bit = b[4:0]; flt_aggr_addr = ag;
    m_type[idx] = int'(t); m_addr[idx] = va; m_bit[idx] = b; m_aggr[idx] = ag;
  endtask

  task automatic clr();
    @(posedge clk); #1;
    mem_ce = 1'b0; mem_we = 1'b0; flt_wr_en = 1'b0; flt_clear = 1'b1;
    for (int i = 0; i < NF; i++) m_type[i] = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    drive_idle();
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_queue_empty", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; mem_ce = 1'b0; mem_we = 1'b0; flt_wr_en = 1'b0; flt_clear = 1'b0;
    @(posedge clk); #1;
    check("rst_rvalid", mem_rvalid, 0);
    check("rst_rdata", mem_rdata, 0);
    check("rst_fault_hit", fault_hit, 0);
    check("rst_hit_cnt", fault_hit_cnt, 0);
    check("rst_access_count", access_count, 0);
    check("rst_init_busy", init_busy, 1);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    for (int i = 0; i < NF; i++) m_type[i] = 0;
    acc_exp = 0;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (init_busy === 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("init_busy_cycles", n, 1024);
  endtask

  // Monitor: pops one expectation per read strobe.
  initial begin
    exp_t e;
    logic [15:0] mon_hits;
    mon_hits = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_hits = 0;
      end else if (mem_rvalid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rvalid: got rdata %0h with no read outstanding", mem_rdata);
        end else begin
          e = sb_q.pop_front();
          check("rdata", mem_rdata, e.data);
          check("fault_hit", fault_hit, e.hit);
          if (e.hit) mon_hits++;
          check("fault_hit_cnt", fault_hit_cnt, mon_hits);
        end
      end else if (fault_hit !== 1'b0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL fault_hit_without_rvalid: got %b expected 0", fault_hit);
      end
    end
  end

  initial begin
    int t;
    logic [9:0] a;
    for (int i = 0; i < NF; i++) begin
      m_type[i] = 0; m_addr[i] = '0; m_aggr[i] = '0; m_bit[i] = 0;
    end

    // T1: reset, init length, write/read latency
    do_reset();
    wait_init();
    op_write(10'd5, 32'hA5A5A5A5);
    op_read_exp(10'd5, 32'hA5A5A5A5, 1'b0);
    drive_idle();
    check("t1_rvalid_lat1", mem_rvalid, 1);
    check("t1_rdata", mem_rdata, 32'hA5A5A5A5);
    @(posedge clk); #1;
    check("t1_rvalid_one_cycle", mem_rvalid, 0);

    // T2: SAF0
    cfg(0, 3'd1, 10'd5, 0, 10'd0);
    op_write(10'd5, 32'hFFFFFFFF);
    op_read_exp(10'd5, 32'hFFFFFFFE, 1'b1);
    clr();
    op_read_exp(10'd5, 32'hFFFFFFFF, 1'b0);
    drain();

    // T3: SAF1 and TF
    cfg(0, 3'd2, 10'd7, 31, 10'd0);
    cfg(1, 3'd3, 10'd9, 3, 10'd0);
    op_write(10'd7, 32'h0);
    op_read_exp(10'd7, 32'h80000000, 1'b1);
    op_write(10'd9, 32'hFFFFFFFF);
    op_read_exp(10'd9, 32'hFFFFFFF7, 1'b0);
    clr();
    drain();

    // T4: CF aggressor 10 -> victim 11 bit 2
    cfg(0, 3'd4, 10'd11, 2, 10'd10);
    op_write(10'd10, 32'h0);
    op_write(10'd11, 32'h0);
    op_write(10'd10, 32'h4);
    op_read_exp(10'd11, 32'h4, 1'b0);
    op_write(10'd10, 32'h4);
    op_read_exp(10'd11, 32'h4, 1'b0);
    clr();
    drain();

    // T5: AF 20 -> 21
    cfg(0, 3'd5, 10'd20, 0, 10'd21);
    op_write(10'd20, 32'h1234);
    op_read_exp(10'd21, 32'h1234, 1'b0);
    op_read_exp(10'd20, 32'h1234, 1'b1);
    clr();
    drain();

    // Randomized rounds on a small address window so faults collide often.
    for (int r = 0; r < 4; r++) begin
      clr();
      for (int i = 0; i < NF; i++) begin
        if (i < 3) begin
          case ($urandom_range(0, 5))
            0: t = 0; 1: t = 1; 2: t = 2; 3: t = 3; 4: t = 5; default: t = 6;
          endcase
        end else begin
          t = $urandom_range(0, 4);
        end
        cfg(i, 3'(t), 10'(40 + $urandom_range(0, 7)), $urandom_range(0, 7),
            10'(40 + $urandom_range(0, 7)));
      end
      for (int k = 0; k < 60; k++) begin
        a = 10'(40 + $urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) op_write(a, $urandom);
        else op_read(a);
      end
      drain();
    end
    check("access_count", access_count, acc_exp);

    // T6: reset during INIT restarts the clear; reads in INIT are dropped
    clr();
    drain();
    do_reset();
    repeat (499) @(posedge clk);
    #1;
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 10'd5;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    check("t6_init_busy_mid", init_busy, 1);
    check("t6_access_count_init", access_count, 0);
    do_reset();
    wait_init();
    op_write(10'd3, 32'h55);
    op_read(10'd3);
    drain();
    check("t6_access_count_after", access_count, acc_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
